cnn_out_writer: RTL and testbench

Downstream stage of the CNN unit. Accepts the stream of 8-bit CNN results, packs them into 128-bit memory lines, and issues write requests on the output memory write channel starting at the software-supplied return address. It runs a single job per start pulse, and reports busy and done to software.

---
 rtl/cnn_out_writer.sv | 83 ++++++++
 tb/tb_cnn_out_writer.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/cnn_out_writer.sv
// cnn_out_writer: packs 8-bit CNN results into 128-bit lines and issues memory write requests
module cnn_out_writer #(
  parameter int ADDR_WIDTH = 12,
  parameter int MEM_DATA_BUS = 128,
  parameter int MAX_BYTES_TO_WR = 16,
  parameter int LOG2_MAX_BYTES_TO_WR = $clog2(MAX_BYTES_TO_WR + 1),
  parameter int CNT_WIDTH = 16
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            sw_start,
  input  logic [ADDR_WIDTH-1:0]           sw_addr_z,
  input  logic [CNT_WIDTH-1:0]            sw_num_results,
  output logic                            busy,
  output logic                            done,
  input  logic [7:0]                      res_data,
  input  logic                            res_vld,
  output logic                            res_rdy,
  output logic                            out_mem_wr_req,
  output logic [ADDR_WIDTH-1:0]           out_mem_start_addr,
  output logic [LOG2_MAX_BYTES_TO_WR-1:0] out_mem_bytes,
  output logic [MEM_DATA_BUS-1:0]         out_mem_data,
  input  logic                            out_mem_ack
);
  localparam int LANE_W = $clog2(MAX_BYTES_TO_WR);
  typedef enum logic [1:0] {IDLE, FILL, WR, DONE} state_t;
  state_t state;
  logic [CNT_WIDTH-1:0] remain_q;
  logic last, full;
  assign last = remain_q == CNT_WIDTH'(1);
  assign full = out_mem_bytes == LOG2_MAX_BYTES_TO_WR'(MAX_BYTES_TO_WR - 1);
  // job FSM; the request outputs are the address, byte index and line buffer registers themselves
  always_ff @(posedge clk) begin
    if (rst) begin
      state              <= IDLE;
      busy               <= 1'b0;
      done               <= 1'b0;
      res_rdy            <= 1'b0;
      out_mem_wr_req     <= 1'b0;
      out_mem_start_addr <= '0;
      out_mem_bytes      <= '0;
      out_mem_data       <= '0;
      remain_q           <= '0;
    end else begin
      case (state)
        IDLE: if (sw_start) begin
          out_mem_start_addr <= sw_addr_z;
          remain_q           <= sw_num_results;
          out_mem_bytes      <= '0;
          out_mem_data       <= '0;
          busy               <= 1'b1;
          state              <= sw_num_results != '0 ? FILL : DONE;
          res_rdy            <= sw_num_results != '0;
          done               <= sw_num_results == '0;
        end
        FILL: if (res_vld && res_rdy) begin
          out_mem_data[{out_mem_bytes[LANE_W-1:0], 3'b000} +: 8] <= res_data;
          out_mem_bytes <= out_mem_bytes + LOG2_MAX_BYTES_TO_WR'(1);
          remain_q      <= remain_q - CNT_WIDTH'(1);
          if (full || last) begin
            state          <= WR;
            res_rdy        <= 1'b0;
            out_mem_wr_req <= 1'b1;
          end
        end
        WR: if (out_mem_ack) begin
          out_mem_start_addr <= out_mem_start_addr + ADDR_WIDTH'(out_mem_bytes);
          out_mem_bytes      <= '0;
          out_mem_data       <= '0;
          out_mem_wr_req     <= 1'b0;
          state              <= remain_q != '0 ? FILL : DONE;
          res_rdy            <= remain_q != '0;
          done               <= remain_q == '0;
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_cnn_out_writer.sv
// tb_cnn_out_writer: randomized self-checking bench against a line-chunking model of the writer
module tb_cnn_out_writer;
  typedef struct packed {
    logic [11:0]  addr;
    logic [4:0]   bytes;
    logic [127:0] data;
  } req_t;
  logic clk = 1'b0, rst, sw_start, busy, done, res_vld, res_rdy, out_mem_wr_req, out_mem_ack;
  logic [11:0] sw_addr_z, out_mem_start_addr;
  logic [15:0] sw_num_results;
  logic [7:0] res_data;
  logic [4:0] out_mem_bytes;
  logic [127:0] out_mem_data;
  logic [7:0] src_q[$];
  req_t exp_q[$];
  int n_vec = 0, n_err = 0, cyc = 0, start_cyc = 0;
  int done_seen = 0, done_cyc = 0, first_req_cyc = -1, req_len = 0, last_req_len = 0;
  int ack_dly = 1;
  bit ack_rand = 0, spur = 0, vld_always = 1;

  cnn_out_writer dut (
    .clk(clk), .rst(rst), .sw_start(sw_start), .sw_addr_z(sw_addr_z),
    .sw_num_results(sw_num_results), .busy(busy), .done(done),
    .res_data(res_data), .res_vld(res_vld), .res_rdy(res_rdy),
    .out_mem_wr_req(out_mem_wr_req), .out_mem_start_addr(out_mem_start_addr),
    .out_mem_bytes(out_mem_bytes), .out_mem_data(out_mem_data), .out_mem_ack(out_mem_ack)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // producer: valid/ready source that holds a presented byte until it is taken
  initial begin
    bit fire;
    res_vld = 1'b0;
    res_data = 8'h00;
    forever begin
      @(negedge clk);
      fire = res_vld && res_rdy && !rst;
      @(posedge clk);
      #1;
      if (fire && src_q.size() > 0) void'(src_q.pop_front());
      if (!(res_vld && !fire && src_q.size() > 0)) begin
        res_vld = src_q.size() > 0 && (vld_always || $urandom_range(0, 2) != 0);
        res_data = src_q.size() > 0 ? src_q[0] : 8'h00;
      end
    end
  end

  // memory: acks each request after a fixed or random delay, optionally sprinkles stray acks
  initial begin
    int wcnt, tgt;
    wcnt = 0;
    tgt = 0;
    out_mem_ack = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (rst) begin
        wcnt = 0;
        out_mem_ack = 1'b0;
      end else if (out_mem_ack) out_mem_ack = 1'b0;
      else if (out_mem_wr_req) begin
        if (wcnt == 0) tgt = ack_rand ? int'($urandom_range(0, 4)) : ack_dly;
        if (wcnt >= tgt) begin
          out_mem_ack = 1'b1;
          wcnt = 0;
        end else wcnt++;
      end else if (spur && $urandom_range(0, 7) == 0) out_mem_ack = 1'b1;
    end
  end

  // compare process: every request cycle must match the head of the expected request list
  initial forever begin
    @(negedge clk);
    if (rst) req_len = 0;
    else begin
      if (sw_start && !busy) first_req_cyc = -1;
      if (out_mem_wr_req) begin
        check("req_pending", 128'(exp_q.size() != 0), 128'd1);
        check("rdy_low_in_wr", 128'(res_rdy), 128'd0);
        if (exp_q.size() != 0) begin
          check("req_addr", 128'(out_mem_start_addr), 128'(exp_q[0].addr));
          check("req_bytes", 128'(out_mem_bytes), 128'(exp_q[0].bytes));
          check("req_data", out_mem_data, exp_q[0].data);
          if (first_req_cyc < 0) first_req_cyc = cyc;
          req_len++;
          if (out_mem_ack) begin
            void'(exp_q.pop_front());
            last_req_len = req_len;
            req_len = 0;
          end
        end
      end
      if (done) begin
        done_seen++;
        done_cyc = cyc;
        check("done_busy", 128'(busy), 128'd1);
      end
    end
  end

  // queue the job's bytes and the lines the memory must receive
  task automatic build(input logic [11:0] a, input int n, input bit seq);
    logic [7:0] b[$];
    for (int i = 0; i < n; i++) b.push_back(seq ? 8'(i) : 8'($urandom));
    foreach (b[i]) src_q.push_back(b[i]);
    for (int k = 0; k * 16 < n; k++) begin
      req_t r;
      r.addr = a + 12'(16 * k);
      r.bytes = 5'((n - 16 * k) > 16 ? 16 : n - 16 * k);
      r.data = '0;
      for (int j = 0; j < int'(r.bytes); j++) r.data[8 * j +: 8] = b[16 * k + j];
      exp_q.push_back(r);
    end
  endtask

  task automatic start_wait(input logic [11:0] a, input int n, input int glitch);
    int d0;
    d0 = done_seen;
    @(posedge clk);
    #1;
    sw_addr_z = a;
    sw_num_results = 16'(n);
    sw_start = 1'b1;
    start_cyc = cyc;
    @(posedge clk);
    #1;
    sw_start = 1'b0;
    check("start_busy", 128'(busy), 128'd1);
    check("start_rdy", 128'(res_rdy), 128'(n != 0));
    check("start_done", 128'(done), 128'(n == 0));
    for (int i = 0; i < 3000 && done_seen == d0; i++) begin
      @(negedge clk);
      if (i == glitch) begin
        sw_start = 1'b1;
        sw_addr_z = 12'($urandom);
        sw_num_results = 16'($urandom_range(1, 40));
      end else sw_start = 1'b0;
    end
    sw_start = 1'b0;
    check("done_pulses", 128'(done_seen - d0), 128'd1);
    check("all_lines_written", 128'(exp_q.size()), 128'd0);
    check("all_bytes_taken", 128'(src_q.size()), 128'd0);
    @(posedge clk);
    #1;
    check("idle_busy", 128'(busy), 128'd0);
    check("idle_done", 128'(done), 128'd0);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_busy"}, 128'(busy), 128'd0);
    check({tag, "_done"}, 128'(done), 128'd0);
    check({tag, "_rdy"}, 128'(res_rdy), 128'd0);
    check({tag, "_req"}, 128'(out_mem_wr_req), 128'd0);
    check({tag, "_addr"}, 128'(out_mem_start_addr), 128'd0);
    check({tag, "_bytes"}, 128'(out_mem_bytes), 128'd0);
    check({tag, "_data"}, out_mem_data, 128'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    bit seen;
    rst = 1'b1;
    sw_start = 1'b0;
    sw_addr_z = '0;
    sw_num_results = '0;
    repeat (3) @(posedge clk);
    #1;
    check_zero("reset");
    rst = 1'b0;

    build(12'h100, 16, 1);
    check("model_line16", exp_q[0].data, 128'h0F0E0D0C0B0A09080706050403020100);
    start_wait(12'h100, 16, -1);
    check("fill_to_req", 128'(first_req_cyc - start_cyc), 128'd17);
    check("job_span", 128'(done_cyc - start_cyc), 128'd19);

    build(12'h100, 20, 1);
    check("model_tail_addr", 128'(exp_q[1].addr), 128'h110);
    check("model_tail_bytes", 128'(exp_q[1].bytes), 128'd4);
    check("model_tail_data", exp_q[1].data, 128'h13121110);
    start_wait(12'h100, 20, -1);

    ack_dly = 6;
    build(12'h240, 16, 0);
    start_wait(12'h240, 16, -1);
    check("stall_req_cycles", 128'(last_req_len), 128'd7);

    ack_dly = 1;
    start_wait(12'h3A5, 0, -1);
    check("n0_done_latency", 128'(done_cyc - start_cyc), 128'd1);

    build(12'hFF0, 32, 0);
    check("model_wrap_addr", 128'(exp_q[1].addr), 128'h000);
    start_wait(12'hFF0, 32, 5);

    spur = 1;
    vld_always = 0;
    build(12'h020, 40, 0);
    start_wait(12'h020, 40, 8);

    ack_rand = 1;
    for (int j = 0; j < 14; j++) begin
      logic [11:0] a;
      vld_always = 1'($urandom_range(0, 1));
      n = $urandom_range(0, 70);
      a = 12'($urandom);
      build(a, n, 0);
      start_wait(a, n, n >= 16 ? 4 : -1);
    end

    spur = 0;
    ack_rand = 0;
    ack_dly = 10000;
    vld_always = 1;
    build(12'h100, 20, 1);
    @(posedge clk);
    #1;
    sw_addr_z = 12'h100;
    sw_num_results = 16'd20;
    sw_start = 1'b1;
    @(posedge clk);
    #1;
    sw_start = 1'b0;
    seen = 0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      seen = out_mem_wr_req;
    end
    check("reset_test_req_seen", 128'(seen), 128'd1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_zero("mid_wr_reset");
    @(posedge clk);
    #1;
    rst = 1'b0;
    src_q.delete();
    exp_q.delete();
    ack_dly = 1;
    spur = 1;
    repeat (12) @(posedge clk);
    #1;
    spur = 0;
    check("stray_ack_idle_busy", 128'(busy), 128'd0);
    check("stray_ack_idle_req", 128'(out_mem_wr_req), 128'd0);

    build(12'h100, 16, 1);
    start_wait(12'h100, 16, -1);
    check("post_reset_fill_to_req", 128'(first_req_cyc - start_cyc), 128'd17);
    check("post_reset_job_span", 128'(done_cyc - start_cyc), 128'd19);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
